muldiv_hilo_ctrl: RTL and testbench

- Multi-cycle controller for MULT/MULTU/DIV/DIVU in the EXE stage.
- Latches the forwarded operands, sequences a fixed-latency multiplier or a 1-bit/cycle restoring divider, and holds the pipeline via a stall request.
- Presents the 64-bit HI/LO result for one cycle so the instruction leaves EXE with its result.
- Sits beside the ALU; its stall feeds the hazard unit (IF_PCWr, IF_IDWr, EXE hold), and its result feeds the HI/LO write path.

---
 rtl/muldiv_hilo_ctrl_pkg.sv | 33 +++
 rtl/muldiv_hilo_ctrl_if.sv | 25 ++
 rtl/muldiv_hilo_ctrl_div_restoring.sv | 54 +++++
 rtl/muldiv_hilo_ctrl.sv | 138 +++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared types and constants for the EXE-stage multiply/divide controller.
package muldiv_hilo_ctrl_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_BITS  = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Two's-complement negate when neg is set (magnitude/sign conversion both ways).
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? XLEN'(-v) : v;
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// EXE-stage operand/flush inputs and HI/LO result outputs of the mul/div controller.
interface muldiv_hilo_ctrl_if;
    import muldiv_hilo_ctrl_pkg::*;

    logic [2:0]      EXE_MulDivOp;
    logic [XLEN-1:0] EXE_BusA;
    logic [XLEN-1:0] EXE_BusB;
    logic            EXE_Flush;
    logic            MD_Stall;
    logic            MD_Busy;
    logic            MD_Valid;
    logic [XLEN-1:0] MD_HI;
    logic [XLEN-1:0] MD_LO;

    modport master (
        output EXE_MulDivOp, EXE_BusA, EXE_BusB, EXE_Flush,
        input  MD_Stall, MD_Busy, MD_Valid, MD_HI, MD_LO
    );

    modport slave (
        input  EXE_MulDivOp, EXE_BusA, EXE_BusB, EXE_Flush,
        output MD_Stall, MD_Busy, MD_Valid, MD_HI, MD_LO
    );

endinterface

// File: rtl/muldiv_hilo_ctrl_div_restoring.sv
// Unsigned restoring divider, one quotient bit per enabled cycle; the _c outputs
// are the results of the iteration running this cycle.
module muldiv_hilo_ctrl_div_restoring
    import muldiv_hilo_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_en,
    output logic [XLEN-1:0] o_quo_c,
    output logic [XLEN-1:0] o_rem_c,
    output logic            o_done_c
);

    logic [XLEN-1:0]      r_rem;
    logic [XLEN-1:0]      r_quo;
    logic [XLEN-1:0]      r_dvs;
    logic [DIV_CNT_W-1:0] r_cnt;

    logic [XLEN:0]        w_trial;
    logic [XLEN+1:0]      w_diff;
    logic                 w_ge;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        w_trial  = {r_rem, r_quo[XLEN-1]};
        w_diff   = {1'b0, w_trial} - {2'b00, r_dvs};
        w_ge     = ~w_diff[XLEN+1];
        o_rem_c  = w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
        o_quo_c  = {r_quo[XLEN-2:0], w_ge};
        o_done_c = i_en && (r_cnt == DIV_CNT_W'(DIV_BITS - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
            r_cnt <= '0;
        end else if (i_en) begin
            r_rem <= o_rem_c;
            r_quo <= o_quo_c;
            r_cnt <= r_cnt + DIV_CNT_W'(1);
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// EXE-stage MULT/MULTU/DIV/DIVU sequencer: stalls the pipeline while busy and
// presents HI/LO for exactly one DONE cycle.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_hilo_ctrl_if.slave  md_if
);

    localparam int unsigned CNT_W = 3;

    muldiv_state_e     r_state;
    muldiv_state_e     w_state_nxt;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic              r_sa;
    logic              r_sb;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    hilo_t             r_res;
    hilo_t             w_res_nxt;

    logic              w_is_mul;
    logic              w_is_div;
    logic              w_signed;
    logic              w_start;
    logic              w_sa;
    logic              w_sb;
    logic              w_stall;
    logic              w_valid;
    logic              w_div_en;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_quo;
    logic [XLEN-1:0]   w_div_rem;
    logic [2*XLEN-1:0] w_prod;

    assign w_is_mul = (md_if.EXE_MulDivOp == MD_MULT) || (md_if.EXE_MulDivOp == MD_MULTU);
    assign w_is_div = (md_if.EXE_MulDivOp == MD_DIV)  || (md_if.EXE_MulDivOp == MD_DIVU);
    assign w_signed = (md_if.EXE_MulDivOp == MD_MULT) || (md_if.EXE_MulDivOp == MD_DIV);
    assign w_start  = (w_is_mul || w_is_div) && !md_if.EXE_Flush;
    assign w_sa     = w_signed & md_if.EXE_BusA[XLEN-1];
    assign w_sb     = w_signed & md_if.EXE_BusB[XLEN-1];
    assign w_div_en = (r_state == ST_DIV) && !md_if.EXE_Flush;

    // Latched signs double as the 33rd bit, so one signed multiply covers MULT and MULTU.
    assign w_prod = 64'($signed({r_sa, r_a})) * 64'($signed({r_sb, r_b}));

    muldiv_hilo_ctrl_div_restoring u_div (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_start && (r_state == ST_IDLE)),
        .i_dividend (neg_if(md_if.EXE_BusA, w_sa)),
        .i_divisor  (neg_if(md_if.EXE_BusB, w_sb)),
        .i_en       (w_div_en),
        .o_quo_c    (w_div_quo),
        .o_rem_c    (w_div_rem),
        .o_done_c   (w_div_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_res_nxt   = r_res;
        w_stall     = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_stall     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_is_mul ? ST_MUL : ST_DIV;
                end
            end
            ST_MUL: begin
                if (md_if.EXE_Flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(MUL_LATENCY - 1)) begin
                        w_state_nxt = ST_DONE;
                        w_res_nxt   = w_prod;
                    end
                end
            end
            ST_DIV: begin
                if (md_if.EXE_Flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (w_div_done) begin
                        w_state_nxt  = ST_DONE;
                        w_res_nxt.hi = neg_if(w_div_rem, r_sa);
                        w_res_nxt.lo = neg_if(w_div_quo, r_sa ^ r_sb);
                    end
                end
            end
            ST_DONE: begin
                w_valid     = !md_if.EXE_Flush;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_res   <= w_res_nxt;
            if ((r_state == ST_IDLE) && w_start) begin
                r_a  <= md_if.EXE_BusA;
                r_b  <= md_if.EXE_BusB;
                r_sa <= w_sa;
                r_sb <= w_sb;
            end
        end
    end

    // Stall is combinational from the inputs, so it is masked while reset is held.
    assign md_if.MD_Stall = w_stall & rst;
    assign md_if.MD_Busy  = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign md_if.MD_Valid = w_valid;
    assign md_if.MD_HI    = r_res.hi;
    assign md_if.MD_LO    = r_res.lo;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// plus directed literal cases and constrained-random stimulus.
module tb_muldiv_hilo_ctrl;
    import muldiv_hilo_ctrl_pkg::*;

    localparam int MUL_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_hilo_ctrl_if u_if ();

    muldiv_hilo_ctrl #(.MUL_LATENCY(MUL_LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .md_if (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [31:0] ma, mb, q, r;
        case (op)
            MD_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            MD_MULTU: return {32'd0, a} * {32'd0, b};
            MD_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            MD_DIV: begin
                ma = a[31] ? -a : a;
                mb = b[31] ? -b : b;
                if (mb == 32'd0) begin
                    q = 32'hFFFF_FFFF;
                    r = ma;
                end else begin
                    q = ma / mb;
                    r = ma % mb;
                end
                if (a[31] ^ b[31]) q = -q;
                if (a[31]) r = -r;
                return {r, q};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Model: cycles remaining until DONE, a DONE flag, and the held HI/LO.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_res = '0;

    always @(negedge clk) begin
        bit e_stall, e_busy, e_valid, start, is_mul;
        start  = (u_if.EXE_MulDivOp >= 3'd1) && (u_if.EXE_MulDivOp <= 3'd4) && !u_if.EXE_Flush;
        is_mul = (u_if.EXE_MulDivOp == 3'd1) || (u_if.EXE_MulDivOp == 3'd2);
        e_stall = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
        if (!rst) begin
            m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
        end else if (m_done) begin
            e_valid = !u_if.EXE_Flush;
        end else if (m_left > 0) begin
            e_busy  = 1'b1;
            e_stall = !u_if.EXE_Flush;
        end else begin
            e_stall = start;
        end
        chk("stall", 64'(u_if.MD_Stall), 64'(e_stall));
        chk("busy",  64'(u_if.MD_Busy),  64'(e_busy));
        chk("valid", 64'(u_if.MD_Valid), 64'(e_valid));
        chk("hi",    64'(u_if.MD_HI),    64'(m_hi));
        chk("lo",    64'(u_if.MD_LO),    64'(m_lo));
        if (rst) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_left > 0) begin
                if (u_if.EXE_Flush) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        {m_hi, m_lo} = m_res;
                    end
                end
            end else if (start) begin
                m_left = is_mul ? MUL_LAT : 32;
                m_res  = md_ref(u_if.EXE_MulDivOp, u_if.EXE_BusA, u_if.EXE_BusB);
            end
        end
    end

    // Holds op until DONE is seen; returns DONE offset from the start cycle and stall count.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls, output logic [31:0] hi, output logic [31:0] lo);
        u_if.EXE_MulDivOp = op;
        u_if.EXE_BusA     = a;
        u_if.EXE_BusB     = b;
        lat = -1; stalls = 0; hi = '0; lo = '0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (u_if.MD_Stall) stalls++;
            if (u_if.MD_Valid) begin
                lat = n; hi = u_if.MD_HI; lo = u_if.MD_LO;
                break;
            end
        end
        @(posedge clk); #1;
        u_if.EXE_MulDivOp = 3'd0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat, st;
        logic [31:0] hi, lo;
        bit          seen_valid;
        u_if.EXE_MulDivOp = 3'd0;
        u_if.EXE_BusA     = '0;
        u_if.EXE_BusB     = '0;
        u_if.EXE_Flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        run_op(3'd4, 32'd100, 32'd7, lat, st, hi, lo);
        chk("divu_lat", 64'(lat), 64'd33); chk("divu_stall", 64'(st), 64'd33);
        chk("divu_lo", 64'(lo), 64'd14);   chk("divu_hi", 64'(hi), 64'd2);

        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, lat, st, hi, lo);
        chk("div_neg_lat", 64'(lat), 64'd33);
        chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD); chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, lat, st, hi, lo);
        chk("mult_lat", 64'(lat), 64'd3); chk("mult_stall", 64'(st), 64'd3);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF); chk("mult_lo", 64'(lo), 64'hFFFF_FFFE);

        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, lat, st, hi, lo);
        chk("multu_hi", 64'(hi), 64'd1); chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        run_op(3'd4, 32'h1234_5678, 32'd0, lat, st, hi, lo);
        chk("dz_stall", 64'(st), 64'd33);
        chk("dz_lo", 64'(lo), 64'hFFFF_FFFF); chk("dz_hi", 64'(hi), 64'h1234_5678);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat, st, hi, lo);
        chk("ovf_lo", 64'(lo), 64'h8000_0000); chk("ovf_hi", 64'(hi), 64'd0);

        // Flush ten cycles into a DIV, then a MULTU immediately after.
        seen_valid = 1'b0;
        u_if.EXE_MulDivOp = 3'd3; u_if.EXE_BusA = 32'd1000; u_if.EXE_BusB = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); if (u_if.MD_Valid) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        u_if.EXE_Flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 64'(u_if.MD_Stall), 64'd0);
        if (u_if.MD_Valid) seen_valid = 1'b1;
        @(posedge clk); #1;
        u_if.EXE_Flush = 1'b0;
        run_op(3'd2, 32'd3, 32'd5, lat, st, hi, lo);
        chk("flush_no_valid", 64'(seen_valid), 64'd0);
        chk("post_flush_lat", 64'(lat), 64'd3); chk("post_flush_lo", 64'(lo), 64'd15);

        // Asynchronous reset mid-DIV.
        u_if.EXE_MulDivOp = 3'd3; u_if.EXE_BusA = 32'd77; u_if.EXE_BusB = 32'd5;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0; u_if.EXE_MulDivOp = 3'd0;
        #1;
        chk("rst_stall", 64'(u_if.MD_Stall), 64'd0); chk("rst_busy", 64'(u_if.MD_Busy), 64'd0);
        chk("rst_valid", 64'(u_if.MD_Valid), 64'd0);
        chk("rst_hi", 64'(u_if.MD_HI), 64'd0);       chk("rst_lo", 64'(u_if.MD_LO), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); if (u_if.MD_Valid || u_if.MD_Busy) seen_valid = 1'b1;
        end
        chk("rst_quiet", 64'(seen_valid), 64'd0);
        @(posedge clk); #1;

        // Random ops, operands and occasional flushes every cycle.
        for (int c = 0; c < 3000; c++) begin
            u_if.EXE_MulDivOp = 3'($urandom_range(0, 7));
            u_if.EXE_BusA     = pick();
            u_if.EXE_BusB     = pick();
            u_if.EXE_Flush    = ($urandom_range(0, 19) == 0);
            @(posedge clk); #1;
        end
        u_if.EXE_MulDivOp = 3'd0;
        u_if.EXE_Flush    = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
